mcu_spi_slave: RTL

//  SPI slave front end for the MCU link, sitting directly upstream of the system-control and other MCU-facing targets.

---
 rtl/mcu_spi_slave_pkg.sv | 17 +
 rtl/mcu_spi_slave_sync_edge.sv | 38 +++
 rtl/mcu_spi_slave.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mcu_spi_slave_pkg.sv
// mcu_spi_slave_pkg
//   Shared definitions for the MCU SPI slave and its consumers:
//   target ids on the MCU link and the slave FSM encoding.
package mcu_spi_slave_pkg;

    localparam logic [7:0] MCU_TGT_SYS = 8'd0;
    localparam logic [7:0] MCU_TGT_HID = 8'd1;
    localparam logic [7:0] MCU_TGT_OSD = 8'd2;
    localparam logic [7:0] MCU_TGT_SDC = 8'd3;

    typedef enum logic [1:0] {
        SPI_IDLE    = 2'd0,
        SPI_SELECT  = 2'd1,
        SPI_PAYLOAD = 2'd2
    } spi_state_e;

endpackage

// File: rtl/mcu_spi_slave_sync_edge.sv
// sync_edge
//   Multi-flop synchroniser for an asynchronous input plus optional
//   single-clk rise/fall pulses derived from the synchronised level.
// Ports
//   clk, reset_n : system clock, async active-low reset (all flops to 0)
//   d            : asynchronous input
//   q            : synchronised level
//   rise, fall   : one-clk pulses on synchronised edges (0 when EDGES=0)
module sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGES  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = EDGES ? (q & ~prev_q) : 1'b0;
    assign fall = EDGES ? (~q & prev_q) : 1'b0;

endmodule

// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave
//   SPI mode-0 slave (MSB first) for the MCU link. The first byte of each
//   frame selects a target; following bytes are handed to that target as
//   data_in with a one-hot strobe. The selected target's data_out byte is
//   loaded two clks after each completed byte and shifted out on MISO.
// Ports
//   clk, reset_n    : system clock (>= 8x SCK), async active-low reset
//   spi_io_ss/clk/din : SPI pins, asynchronous to clk
//   spi_io_dout     : MISO, tx_shift[7] while SS low, else 0
//   data_in         : last received payload byte
//   data_in_start   : set with the first payload strobe of a frame
//   data_in_strobe  : one-clk, one-hot per target
//   target          : target id from the frame's first byte
//   data_out        : reply bytes, target t at [8t+7:8t]
module mcu_spi_slave
    import mcu_spi_slave_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spi_io_ss,
    input  logic                     spi_io_clk,
    input  logic                     spi_io_din,
    output logic                     spi_io_dout,
    output logic [7:0]               data_in,
    output logic                     data_in_start,
    output logic [NUM_TARGETS-1:0]   data_in_strobe,
    output logic [7:0]               target,
    input  logic [8*NUM_TARGETS-1:0] data_out
);

    logic ss_rise, ss_fall, sck_rise, sck_fall, din_q;
    logic ss_lvl_unused, sck_lvl_unused, din_rise_unused, din_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_ss_sync (
        .clk(clk), .reset_n(reset_n), .d(spi_io_ss),
        .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sck_sync (
        .clk(clk), .reset_n(reset_n), .d(spi_io_clk),
        .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_din_sync (
        .clk(clk), .reset_n(reset_n), .d(spi_io_din),
        .q(din_q), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    spi_state_e state, state_nxt;

    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic                   first_pl;
    // ld_pipe[0]: byte completed last clk (strobe now visible),
    // ld_pipe[1]: consumer has registered it, load tx this clk.
    logic [1:0]             ld_pipe;

    logic [7:0]             rx_byte;
    logic                   byte_done;
    logic [NUM_TARGETS-1:0] strobe_dec;
    logic [7:0]             tx_sel;

    assign rx_byte = {rx_shift[6:0], din_q};
    // SS rise wins over a coincident 8th SCK rise: the byte is dropped.
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != SPI_IDLE) && !ss_rise;

    // Out-of-range targets decode to no strobe and a zero reply.
    always_comb begin
        strobe_dec = '0;
        tx_sel     = '0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (target == 8'(t)) begin
                strobe_dec[t] = 1'b1;
                tx_sel        = data_out[8*t +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SPI_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_rise) begin
            state_nxt = SPI_IDLE;
        end else begin
            case (state)
                SPI_IDLE:    if (ss_fall) state_nxt = SPI_SELECT;
                SPI_SELECT:  if (byte_done) state_nxt = SPI_PAYLOAD;
                SPI_PAYLOAD: state_nxt = SPI_PAYLOAD;
                default:     state_nxt = SPI_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            first_pl       <= 1'b0;
            ld_pipe        <= '0;
            data_in        <= '0;
            data_in_start  <= 1'b0;
            data_in_strobe <= '0;
            target         <= '0;
        end else begin
            data_in_strobe <= '0;
            ld_pipe        <= ss_rise ? 2'b00 : {ld_pipe[0], byte_done};

            if (!ss_rise) begin
                if (state == SPI_IDLE) begin
                    if (ss_fall) begin
                        bit_cnt  <= '0;
                        tx_shift <= '0;
                    end
                end else begin
                    if (sck_rise) begin
                        rx_shift <= rx_byte;
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        if (state == SPI_SELECT) begin
                            target   <= rx_byte;
                            first_pl <= 1'b1;
                        end else begin
                            data_in        <= rx_byte;
                            data_in_start  <= first_pl;
                            data_in_strobe <= strobe_dec;
                            first_pl       <= 1'b0;
                        end
                    end
                    // bit_cnt==0 on the fall after the 8th bit: hold the
                    // shifter so the pending load sees an unshifted register.
                    if (ld_pipe[1])
                        tx_shift <= tx_sel;
                    else if (sck_fall && bit_cnt != 3'd0)
                        tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_io_dout = ~spi_io_ss & tx_shift[7];

    // SCK must not rise while the reply load is still pending.
    sck_rise_during_load_a: assert property (
        @(posedge clk) disable iff (!reset_n) !(sck_rise && (|ld_pipe))
    );

endmodule
